enc83_drain: RTL and testbench

- Sequential 8-to-3 encoder; the inverse direction of the 3-to-8 decoder path.
- Accepts an 8-bit request vector over a valid/ready handshake.
- Emits the 3-bit index of every set bit, one index per output handshake, highest bit first.
- Sits between request-generating logic and a consumer that needs one index per beat, e.g. a 3-to-8 decoder driving one-hot selects.

---
 rtl/enc83_drain.sv | 95 +++++++++
 tb/tb_enc83_drain.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/enc83_drain.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of every
// set bit, highest first, one index per output handshake.
module enc83_drain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] Data_out,
    output logic             out_last,
    output logic [3:0]       out_cnt,
    output logic             zero_err
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   pending_q;
    logic [3:0]         cnt_q;
    logic               zero_err_q;

    logic [IDX_W-1:0]   top_idx;
    logic [WIDTH-1:0]   top_bit;
    logic               last_bit;

    function automatic logic [3:0] popcount(input logic [WIDTH-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

    // Ascending scan so the highest set bit wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
                top_idx = IDX_W'(i);
            end
        end
        top_bit          = '0;
        top_bit[top_idx] = 1'b1;
        last_bit         = (pending_q & ~top_bit) == '0;
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDrain);
        Data_out  = out_valid ? top_idx : '0;
        out_last  = out_valid & last_bit;
        out_cnt   = cnt_q;
        zero_err  = zero_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            cnt_q      <= 4'd0;
            zero_err_q <= 1'b0;
        end else begin
            zero_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (Data_in != '0) begin
                            pending_q <= Data_in;
                            cnt_q     <= popcount(Data_in);
                            state_q   <= StDrain;
                        end else begin
                            zero_err_q <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        pending_q <= pending_q & ~top_bit;
                        if (last_bit) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_enc83_drain.sv
// Directed bench for enc83_drain; outputs are checked 1 time unit after each rising edge.
module tb_enc83_drain;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Data_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] Data_out;
    logic       out_last;
    logic [3:0] out_cnt;
    logic       zero_err;

    int n_cmp = 0;
    int n_err = 0;

    enc83_drain #(.WIDTH(8), .IDX_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data_in   (Data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Data_out  (Data_out),
        .out_last  (out_last),
        .out_cnt   (out_cnt),
        .zero_err  (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Data_in   = 8'h00;

        // Reset then idle
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", Data_out, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_zero_err", zero_err, 0);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", in_ready, 1);

        // Sparse vector 1010_0100 with a 2-cycle stall on the first beat
        in_valid = 1'b1;
        Data_in  = 8'hA4;
        step();
        in_valid = 1'b0;
        check("sp_valid0", out_valid, 1);
        check("sp_idx7", Data_out, 7);
        check("sp_last7", out_last, 0);
        check("sp_cnt", out_cnt, 3);
        check("sp_in_ready", in_ready, 0);
        step();
        check("sp_stall1_idx", Data_out, 7);
        check("sp_stall1_valid", out_valid, 1);
        step();
        check("sp_stall2_idx", Data_out, 7);
        check("sp_stall2_last", out_last, 0);
        out_ready = 1'b1;
        step();
        check("sp_idx5", Data_out, 5);
        check("sp_last5", out_last, 0);
        step();
        check("sp_idx2", Data_out, 2);
        check("sp_last2", out_last, 1);
        step();
        check("sp_done_valid", out_valid, 0);
        check("sp_done_ready", in_ready, 1);
        check("sp_done_data", Data_out, 0);
        check("sp_done_last", out_last, 0);
        check("sp_cnt_hold", out_cnt, 3);

        // Full vector
        in_valid = 1'b1;
        Data_in  = 8'hFF;
        step();
        in_valid = 1'b0;
        check("ff_cnt", out_cnt, 8);
        for (int k = 7; k >= 0; k--) begin
            check("ff_valid", out_valid, 1);
            check("ff_idx", Data_out, k);
            check("ff_last", out_last, (k == 0) ? 1 : 0);
            step();
        end
        check("ff_done_ready", in_ready, 1);
        check("ff_done_valid", out_valid, 0);

        // Zero vector
        in_valid = 1'b1;
        Data_in  = 8'h00;
        step();
        in_valid = 1'b0;
        check("z_err", zero_err, 1);
        check("z_valid", out_valid, 0);
        check("z_ready", in_ready, 1);
        check("z_cnt_hold", out_cnt, 8);
        step();
        check("z_err_pulse", zero_err, 0);
        check("z_valid2", out_valid, 0);

        // Input blocked during drain
        in_valid = 1'b1;
        Data_in  = 8'h81;
        step();
        Data_in = 8'h10;
        check("bl_idx7", Data_out, 7);
        check("bl_cnt", out_cnt, 2);
        check("bl_ready", in_ready, 0);
        step();
        check("bl_idx0", Data_out, 0);
        check("bl_last0", out_last, 1);
        check("bl_valid0", out_valid, 1);
        check("bl_cnt_hold", out_cnt, 2);
        step();
        check("bl_idle_ready", in_ready, 1);
        check("bl_idle_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("bl_idx4", Data_out, 4);
        check("bl_last4", out_last, 1);
        check("bl_cnt1", out_cnt, 1);
        step();
        check("bl_end_valid", out_valid, 0);

        // Reset mid-drain
        in_valid = 1'b1;
        Data_in  = 8'h0F;
        step();
        in_valid = 1'b0;
        check("rd_idx3", Data_out, 3);
        check("rd_cnt", out_cnt, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rd_valid_drop", out_valid, 0);
        check("rd_pending", dut.pending_q, 0);
        check("rd_ready", in_ready, 1);
        check("rd_cnt_clr", out_cnt, 0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("rd_no_stale", out_valid, 0);
            check("rd_ready_after", in_ready, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
